// File: rtl/audio_dac_spi.sv
// -----------------------------------------------------------------------------
// audio_dac_spi
//
// Serialises the 12-bit audio sample stream into DAC121S101-style SPI frames.
// An internal free-running divider produces one sample tick every SAMPLE_DIV
// clocks. On a tick, while idle and enabled, one 16-bit frame
// {2'b00, PD_MODE, sample_in} is shifted out MSB first.
//
// Parameters
//   CLK_DIV     clk100M cycles per SCLK half-period (>= 1)
//   SAMPLE_DIV  clk100M cycles per sample tick (> 32*CLK_DIV + 2)
//   PD_MODE     DAC power-down control bits placed in frame[13:12]
//
// Ports
//   clk100M     system clock, all registers rising-edge
//   reset       asynchronous active-high reset
//   enable      1 = start a frame on each sample tick
//   sample_in   unsigned 12-bit sample, captured only on the frame start edge
//   dac_sync    SPI frame select, active-low
//   dac_sclk    SPI clock, idles high
//   dac_din     SPI data, updated on SCLK rising edges
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse on the edge that ends a frame
// -----------------------------------------------------------------------------
module audio_dac_spi #(
    parameter int          CLK_DIV    = 4,
    parameter int          SAMPLE_DIV = 5000,
    parameter logic [1:0]  PD_MODE    = 2'b00
) (
    input  logic        clk100M,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] sample_in,
    output logic        dac_sync,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done
);

    localparam int SMP_W = $clog2(SAMPLE_DIV);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [SMP_W-1:0]   smp_cnt_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [3:0]         bit_cnt_reg;
    logic [15:0]        shreg_reg;

    logic               tick;
    logic [15:0]        frame_word;

    assign tick       = (smp_cnt_reg == SMP_LAST);
    assign frame_word = {2'b00, PD_MODE, sample_in};

    // Sample-rate divider: free-running, unaffected by enable or the FSM.
    always_ff @(posedge clk100M or posedge reset) begin
        if (reset) begin
            smp_cnt_reg <= '0;
        end else if (tick) begin
            smp_cnt_reg <= '0;
        end else begin
            smp_cnt_reg <= smp_cnt_reg + SMP_W'(1);
        end
    end

    // Frame FSM with registered SPI outputs and status flags.
    always_ff @(posedge clk100M or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            dac_sync    <= 1'b1;
            dac_sclk    <= 1'b1;
            dac_din     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tick && enable) begin
                        shreg_reg   <= frame_word;
                        dac_din     <= frame_word[15];
                        dac_sync    <= 1'b0;
                        busy        <= 1'b1;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        if (dac_sclk) begin
                            // Falling edge: the DAC samples dac_din here.
                            dac_sclk <= 1'b0;
                        end else if (bit_cnt_reg == 4'd15) begin
                            // Rising edge after the 16th fall closes the frame.
                            dac_sclk   <= 1'b1;
                            dac_sync   <= 1'b1;
                            dac_din    <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state_reg  <= IDLE;
                        end else begin
                            // Rising edge: present the next bit, MSB first.
                            dac_sclk    <= 1'b1;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            shreg_reg   <= {shreg_reg[14:0], 1'b0};
                            dac_din     <= shreg_reg[14];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dac_spi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_audio_dac_spi
//
// Directed bench for audio_dac_spi with CLK_DIV=2, SAMPLE_DIV=100. A second
// instance with PD_MODE=2'b11 and a zero sample covers the control bits.
// All outputs are sampled on the falling edge of clk100M.
// -----------------------------------------------------------------------------
module tb_audio_dac_spi;

    logic        clk100M;
    logic        reset;
    logic        enable;
    logic [11:0] sample_in;
    logic [11:0] sample_in2;

    logic dac_sync,  dac_sclk,  dac_din,  busy,  frame_done;
    logic dac_sync2, dac_sclk2, dac_din2, busy2, frame_done2;

    int checks = 0;
    int errors = 0;

    audio_dac_spi #(.CLK_DIV(2), .SAMPLE_DIV(100), .PD_MODE(2'b00)) dut (
        .clk100M    (clk100M),
        .reset      (reset),
        .enable     (enable),
        .sample_in  (sample_in),
        .dac_sync   (dac_sync),
        .dac_sclk   (dac_sclk),
        .dac_din    (dac_din),
        .busy       (busy),
        .frame_done (frame_done)
    );

    audio_dac_spi #(.CLK_DIV(2), .SAMPLE_DIV(100), .PD_MODE(2'b11)) dut_pd (
        .clk100M    (clk100M),
        .reset      (reset),
        .enable     (enable),
        .sample_in  (sample_in2),
        .dac_sync   (dac_sync2),
        .dac_sclk   (dac_sclk2),
        .dac_din    (dac_din2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    initial clk100M = 1'b0;
    always #5 clk100M = ~clk100M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for dac_sync to fall, then records one frame: bits sampled on
    // SCLK falls, sync-low length, fall count and frame_done pulses (the
    // latter over the low window plus three samples after it).
    task automatic capture(input int which,
                           output logic [15:0] bits, output int wait_cnt,
                           output int low_cnt, output int falls,
                           output int done_cnt, output logic [11:0] smp_prev,
                           output logic timeout);
        logic s_sync, s_sclk, s_din, s_done, prev_sclk;
        bits = '0; wait_cnt = 0; low_cnt = 0; falls = 0; done_cnt = 0;
        smp_prev = sample_in; timeout = 1'b0; prev_sclk = 1'b1;
        @(negedge clk100M);
        s_sync = which ? dac_sync2 : dac_sync;
        while (s_sync === 1'b1 && wait_cnt < 300) begin
            wait_cnt++;
            smp_prev = sample_in;
            @(negedge clk100M);
            s_sync = which ? dac_sync2 : dac_sync;
        end
        if (s_sync !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        while (s_sync === 1'b0 && low_cnt < 1000) begin
            low_cnt++;
            s_sclk = which ? dac_sclk2 : dac_sclk;
            s_din  = which ? dac_din2  : dac_din;
            s_done = which ? frame_done2 : frame_done;
            if (prev_sclk === 1'b1 && s_sclk === 1'b0) begin
                falls++;
                bits = {bits[14:0], s_din};
            end
            prev_sclk = s_sclk;
            if (s_done === 1'b1) done_cnt++;
            @(negedge clk100M);
            s_sync = which ? dac_sync2 : dac_sync;
        end
        if (s_sync !== 1'b1) timeout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_done = which ? frame_done2 : frame_done;
            if (s_done === 1'b1) done_cnt++;
            if (i < 2) @(negedge clk100M);
        end
    endtask

    logic [15:0] bits;
    int          wait_cnt, low_cnt, falls, done_cnt;
    logic [11:0] smp_prev;
    logic        timeout;
    int          viol, interval, busy_cnt;

    initial begin
        reset = 1'b0; enable = 1'b1; sample_in = 12'hA5C; sample_in2 = 12'h000;
        #2 reset = 1'b1;
        #1;
        // Reset state
        check("rst_sync", dac_sync, 1'b1);
        check("rst_sclk", dac_sclk, 1'b1);
        check("rst_din", dac_din, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        $display("txn reset: sync=%b sclk=%b din=%b busy=%b done=%b", dac_sync, dac_sclk, dac_din, busy, frame_done);
        repeat (3) @(negedge clk100M);
        reset = 1'b0;

        // First frame after release, sample 12'hA5C
        capture(0, bits, wait_cnt, low_cnt, falls, done_cnt, smp_prev, timeout);
        $display("txn frame A5C: bits=%h wait=%0d low=%0d falls=%0d done=%0d", bits, wait_cnt, low_cnt, falls, done_cnt);
        check("a5c_timeout", timeout, 1'b0);
        check("a5c_first_tick_wait", wait_cnt, 99);
        check("a5c_bits", bits, 16'h0A5C);
        check("a5c_sync_low", low_cnt, 64);
        check("a5c_falls", falls, 16);
        check("a5c_done_pulses", done_cnt, 1);

        // Reset in the middle of a frame
        sample_in = 12'h3C5;
        wait_cnt = 0;
        @(negedge clk100M);
        while (dac_sync === 1'b1 && wait_cnt < 300) begin
            wait_cnt++;
            @(negedge clk100M);
        end
        check("mid_frame_reached", dac_sync, 1'b0);
        repeat (20) @(negedge clk100M);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_sync", dac_sync, 1'b1);
        check("mid_rst_sclk", dac_sclk, 1'b1);
        check("mid_rst_din", dac_din, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", frame_done, 1'b0);
        $display("txn mid-frame reset: sync=%b sclk=%b din=%b busy=%b", dac_sync, dac_sclk, dac_din, busy);
        repeat (4) @(negedge clk100M);
        reset = 1'b0;
        capture(0, bits, wait_cnt, low_cnt, falls, done_cnt, smp_prev, timeout);
        $display("txn frame 3C5 after reset: bits=%h wait=%0d low=%0d", bits, wait_cnt, low_cnt);
        check("post_rst_timeout", timeout, 1'b0);
        check("post_rst_wait", wait_cnt, 99);
        check("post_rst_bits", bits, 16'h03C5);

        // enable low for 5 sample periods: bus must stay idle
        enable = 1'b0;
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk100M);
            if (dac_sync !== 1'b1 || dac_sclk !== 1'b1 || frame_done !== 1'b0) viol++;
        end
        $display("txn enable low 500 cycles: violations=%0d", viol);
        check("disabled_idle", viol, 0);
        sample_in = 12'h7E1;
        enable = 1'b1;
        capture(0, bits, wait_cnt, low_cnt, falls, done_cnt, smp_prev, timeout);
        $display("txn frame 7E1 after enable: bits=%h wait=%0d", bits, wait_cnt);
        check("reenable_timeout", timeout, 1'b0);
        check("reenable_within_period", (wait_cnt < 100), 1'b1);
        check("reenable_bits", bits, 16'h07E1);

        // sample_in toggles every cycle during a frame
        sample_in = 12'h000;
        fork
            capture(0, bits, wait_cnt, low_cnt, falls, done_cnt, smp_prev, timeout);
            begin
                for (int i = 0; i < 250; i++) begin
                    @(posedge clk100M);
                    #1 sample_in = ~sample_in;
                end
            end
        join
        $display("txn toggling sample: bits=%h start_value=%h", bits, smp_prev);
        check("toggle_timeout", timeout, 1'b0);
        check("toggle_start_legal", (smp_prev == 12'h000 || smp_prev == 12'hFFF), 1'b1);
        check("toggle_bits", bits, {4'h0, smp_prev});
        check("toggle_sync_low", low_cnt, 64);

        // Continuous run: frame_done spacing and busy duty
        sample_in = 12'h123;
        interval = 0;
        @(negedge clk100M);
        while (frame_done !== 1'b1 && interval < 300) begin
            interval++;
            @(negedge clk100M);
        end
        check("cont_first_done", frame_done, 1'b1);
        interval = 0; busy_cnt = 0;
        do begin
            @(negedge clk100M);
            interval++;
            if (busy === 1'b1) busy_cnt++;
        end while (frame_done !== 1'b1 && interval < 300);
        $display("txn continuous: done interval=%0d busy cycles=%0d", interval, busy_cnt);
        check("cont_done_interval", interval, 100);
        check("cont_busy_duty", busy_cnt, 64);

        // PD_MODE=2'b11 instance with a zero sample
        capture(1, bits, wait_cnt, low_cnt, falls, done_cnt, smp_prev, timeout);
        $display("txn pd_mode 11: bits=%h low=%0d falls=%0d done=%0d", bits, low_cnt, falls, done_cnt);
        check("pd_timeout", timeout, 1'b0);
        check("pd_bits", bits, 16'h3000);
        check("pd_done_pulses", done_cnt, 1);
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk100M);
            if (busy2 !== 1'b0) viol++;
        end
        $display("txn pd_mode gap: busy-high samples=%0d", viol);
        check("pd_busy_gap", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
